screen_sequencer: RTL and testbench



---
 rtl/screen_sequencer.sv | 166 ++++++++++++++++
 tb/tb_screen_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// Screen controller: round timer, title/play/game-over sequencing and the
// registered pixel mux that drives the single OLED data bus.
module screen_sequencer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECONDS  = 60,
  parameter int BLINK_FRAMES   = 8,
  parameter int BLINK_COUNT    = 6,
  parameter int HOLD_SECONDS   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic        start,
  input  logic        guess_correct,
  input  logic [15:0] title_data,
  input  logic [15:0] play_data,
  input  logic [15:0] game_over_data,
  output logic [15:0] oled_data,
  output logic [1:0]  state,
  output logic [6:0]  seconds_left,
  output logic        round_active,
  output logic        round_won
);

  localparam int HOLD_FRAMES = HOLD_SECONDS * FRAMES_PER_SEC;
  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int BW = (BLINK_FRAMES   > 1) ? $clog2(BLINK_FRAMES)   : 1;
  localparam int TW = (BLINK_COUNT    > 1) ? $clog2(BLINK_COUNT)    : 1;
  localparam int HW = (HOLD_FRAMES    > 1) ? $clog2(HOLD_FRAMES)    : 1;

  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(BLINK_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_FRAMES - 1);
  localparam logic [6:0]    ROUND_INIT  = 7'(ROUND_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAYING  = 2'd1,
    S_GO_BLINK = 2'd2,
    S_GO_HOLD  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [TW-1:0] toggle_cnt_q, toggle_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          blink_vis_q, blink_vis_d;
  logic [6:0]    seconds_left_q, seconds_left_d;
  logic          round_won_q, round_won_d;
  logic [15:0]   oled_data_q, oled_data_d;
  logic          begin_round, enter_blink;

  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    toggle_cnt_d   = toggle_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    blink_vis_d    = blink_vis_q;
    seconds_left_d = seconds_left_q;
    round_won_d    = round_won_q;
    oled_data_d    = 16'h0000;
    begin_round    = 1'b0;
    enter_blink    = 1'b0;

    case (state_q)
      S_IDLE: begin
        oled_data_d = title_data;
        if (start) begin_round = 1'b1;
      end
      S_PLAYING: begin
        oled_data_d = play_data;
        // A win beats a coincident timeout wrap, so the guess is tested first.
        if (guess_correct) begin
          round_won_d = 1'b1;
          enter_blink = 1'b1;
        end else if (frame_begin) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            if (seconds_left_q != 7'd0) seconds_left_d = seconds_left_q - 7'd1;
            if (seconds_left_q == 7'd1) enter_blink = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_GO_BLINK: begin
        oled_data_d = blink_vis_q ? game_over_data : 16'h0000;
        if (frame_begin) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d  = '0;
            blink_vis_d  = ~blink_vis_q;
            toggle_cnt_d = toggle_cnt_q + 1'b1;
            if (toggle_cnt_q == TOGGLE_LAST) begin
              state_d    = S_GO_HOLD;
              hold_cnt_d = '0;
            end
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      S_GO_HOLD: begin
        oled_data_d = game_over_data;
        if (start) begin
          begin_round = 1'b1;
        end else if (frame_begin) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = S_IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (begin_round) begin
      state_d        = S_PLAYING;
      seconds_left_d = ROUND_INIT;
      frame_cnt_d    = '0;
      round_won_d    = 1'b0;
    end
    // Blink always starts visible with fresh counters.
    if (enter_blink) begin
      state_d      = S_GO_BLINK;
      blink_cnt_d  = '0;
      toggle_cnt_d = '0;
      blink_vis_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= '0;
      blink_cnt_q    <= '0;
      toggle_cnt_q   <= '0;
      hold_cnt_q     <= '0;
      blink_vis_q    <= 1'b0;
      seconds_left_q <= 7'd0;
      round_won_q    <= 1'b0;
      oled_data_q    <= 16'h0000;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      toggle_cnt_q   <= toggle_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      blink_vis_q    <= blink_vis_d;
      seconds_left_q <= seconds_left_d;
      round_won_q    <= round_won_d;
      oled_data_q    <= oled_data_d;
    end
  end

  assign oled_data    = oled_data_q;
  assign state        = state_q;
  assign seconds_left = seconds_left_q;
  assign round_active = (state_q == S_PLAYING);
  assign round_won    = round_won_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: expected outputs are queued with the
// stimulus and compared once the DUT has responded.
module tb_screen_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_begin = 1'b0;
  logic        start = 1'b0;
  logic        guess_correct = 1'b0;
  logic [15:0] title_data = 16'h1111;
  logic [15:0] play_data = 16'h2222;
  logic [15:0] game_over_data = 16'h3333;
  logic [15:0] oled_data;
  logic [1:0]  state;
  logic [6:0]  seconds_left;
  logic        round_active;
  logic        round_won;

  screen_sequencer #(
    .FRAMES_PER_SEC(4),
    .ROUND_SECONDS (3),
    .BLINK_FRAMES  (2),
    .BLINK_COUNT   (4),
    .HOLD_SECONDS  (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_begin   (frame_begin),
    .start         (start),
    .guess_correct (guess_correct),
    .title_data    (title_data),
    .play_data     (play_data),
    .game_over_data(game_over_data),
    .oled_data     (oled_data),
    .state         (state),
    .seconds_left  (seconds_left),
    .round_active  (round_active),
    .round_won     (round_won)
  );

  always #5 clk = ~clk;

  localparam int O_OLED = 0, O_STATE = 1, O_SEC = 2, O_ACT = 3, O_WON = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      O_OLED:  return oled_data;
      O_STATE: return {14'd0, state};
      O_SEC:   return {9'd0, seconds_left};
      O_ACT:   return {15'd0, round_active};
      O_WON:   return {15'd0, round_won};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    tick();
    sb_drain();
  endtask

  task automatic pulse(input bit fb, input bit st, input bit gc);
    frame_begin   = fb;
    start         = st;
    guess_correct = gc;
    tick();
    frame_begin   = 1'b0;
    start         = 1'b0;
    guess_correct = 1'b0;
    sb_drain();
  endtask

  // One frame period: idle clocks then a frame_begin pulse (optionally with start/guess).
  task automatic frame(input bit st, input bit gc, input int gap);
    repeat (gap) tick();
    pulse(1'b1, st, gc);
  endtask

  task automatic expect_all(input string tag, input logic [1:0] st, input logic [6:0] sec,
                            input logic act, input logic won);
    expect_out({tag, "_state"}, O_STATE, {14'd0, st});
    expect_out({tag, "_sec"},   O_SEC,   {9'd0, sec});
    expect_out({tag, "_act"},   O_ACT,   {15'd0, act});
    expect_out({tag, "_won"},   O_WON,   {15'd0, won});
  endtask

  // Runs the 8 blink frames then checks hold is entered.
  task automatic run_blink(input string tag);
    for (int b = 1; b <= 8; b++) begin
      expect_out($sformatf("%s_bstate%0d", tag, b), O_STATE, (b == 8) ? 16'd3 : 16'd2);
      frame(1'b0, 1'b0, 8);
      expect_out($sformatf("%s_boled%0d", tag, b), O_OLED, ((b / 2) % 2 == 0) ? 16'h3333 : 16'h0000);
      settle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset then idle
    reset = 1'b1;
    expect_all("rst1", 2'd0, 7'd0, 1'b0, 1'b0);
    expect_out("rst1_oled", O_OLED, 16'h0000);
    settle();
    expect_all("rst2", 2'd0, 7'd0, 1'b0, 1'b0);
    expect_out("rst2_oled", O_OLED, 16'h0000);
    settle();
    reset = 1'b0;
    expect_out("idle_oled", O_OLED, 16'h1111);
    expect_out("idle_state", O_STATE, 16'd0);
    settle();

    // Timeout path
    expect_all("start", 2'd1, 7'd3, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    expect_out("play_oled", O_OLED, 16'h2222);
    settle();
    for (int f = 1; f <= 12; f++) begin
      expect_out($sformatf("to_sec%0d", f), O_SEC, 16'(3 - f / 4));
      expect_out($sformatf("to_state%0d", f), O_STATE, (f == 12) ? 16'd2 : 16'd1);
      frame(1'b0, 1'b0, 9);
    end
    expect_out("to_won", O_WON, 16'd0);
    expect_out("to_act", O_ACT, 16'd0);
    expect_out("blink_first_oled", O_OLED, 16'h3333);
    settle();

    // Blink and hold
    run_blink("to");
    for (int h = 1; h <= 4; h++) begin
      expect_out($sformatf("hold_state%0d", h), O_STATE, (h == 4) ? 16'd0 : 16'd3);
      frame(1'b0, 1'b0, 8);
      expect_out($sformatf("hold_oled%0d", h), O_OLED, (h == 4) ? 16'h1111 : 16'h3333);
      settle();
    end

    // Win path
    expect_all("win_start", 2'd1, 7'd3, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    for (int f = 1; f <= 5; f++) begin
      expect_out($sformatf("win_sec%0d", f), O_SEC, (f >= 4) ? 16'd2 : 16'd3);
      frame(1'b0, 1'b0, 9);
    end
    repeat (3) tick();
    expect_all("win", 2'd2, 7'd2, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);

    // Start is ignored during blink
    repeat (3) tick();
    expect_out("blink_start_state", O_STATE, 16'd2);
    pulse(1'b0, 1'b1, 1'b0);
    expect_out("blink_start_won", O_WON, 16'd1);
    expect_out("blink_start_oled", O_OLED, 16'h3333);
    settle();
    run_blink("win");

    // Start and frame_begin together on the last hold frame: start wins
    for (int h = 1; h <= 3; h++) begin
      expect_out($sformatf("hold2_state%0d", h), O_STATE, 16'd3);
      frame(1'b0, 1'b0, 9);
    end
    expect_all("hold_start", 2'd1, 7'd3, 1'b1, 1'b0);
    frame(1'b1, 1'b0, 9);
    expect_out("hold_start_oled", O_OLED, 16'h2222);
    settle();

    // Guess coincident with the final wrap
    for (int f = 1; f <= 11; f++) begin
      expect_out($sformatf("sim_sec%0d", f), O_SEC, 16'(3 - f / 4));
      frame(1'b0, 1'b0, 9);
    end
    expect_all("sim_guess", 2'd2, 7'd1, 1'b0, 1'b1);
    frame(1'b0, 1'b1, 9);
    run_blink("sim");

    // Reset mid-round
    expect_all("rr_start", 2'd1, 7'd3, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    for (int f = 1; f <= 4; f++) frame(1'b0, 1'b0, 9);
    expect_out("rr_pre_sec", O_SEC, 16'd2);
    expect_out("rr_pre_oled", O_OLED, 16'h2222);
    settle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_all("rr", 2'd0, 7'd0, 1'b0, 1'b0);
    expect_out("rr_oled", O_OLED, 16'h0000);
    sb_drain();
    expect_out("rr_idle_oled", O_OLED, 16'h1111);
    settle();

    check_val("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
